serial_to_parallel_rx: RTL

Receive-side deserializer for the LSB-first single-bit serial stream produced by our parallel-to-serial transmitter. It collects `width` valid serial bits into a word and presents it on a registered valid/ready output. The output holds the word until the consumer accepts it, and the block flags overruns. An optional gap timeout discards partial words when the serial stream stalls.

---
 rtl/serial_to_parallel_rx.sv | 96 +++++++++
 1 files changed

// File: rtl/serial_to_parallel_rx.sv
// LSB-first serial-to-parallel receiver with a valid/ready output register and overrun flag.
// Define SERIAL_TO_PARALLEL_RX_TIMEOUT_EN to enable the mid-word gap timeout (frame_error).
module serial_to_parallel_rx #(
    parameter int width   = 8,
    parameter int timeout = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    output logic             busy,
    output logic             parallel_valid,
    input  logic             parallel_ready,
    output logic [width-1:0] parallel_data,
    output logic             overrun,
    output logic             frame_error
);

    localparam int CW = $clog2(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    if (width < 2 || timeout < 1 || timeout > 255) begin : g_bad_params
        $error("serial_to_parallel_rx: illegal width or timeout");
    end

    logic [CW-1:0]    cnt;
    logic [width-1:0] shreg;
    logic [width-1:0] word;
    logic             done;
    logic             expire;

    // Word as it would look with the current bit merged in; used both for
    // shifting and as the completed word on the last bit.
    always_comb begin
        word      = shreg;
        word[cnt] = serial_data;
    end

    assign done = serial_valid && (cnt == LAST);
    assign busy = (cnt != '0);

`ifdef SERIAL_TO_PARALLEL_RX_TIMEOUT_EN
    logic [7:0] gap;

    assign expire = !serial_valid && busy && (gap == 8'(timeout - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            gap         <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= expire;
            if (serial_valid || !busy || expire)
                gap <= '0;
            else
                gap <= gap + 8'd1;
        end
    end
`else
    assign expire      = 1'b0;
    assign frame_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (serial_valid) begin
            shreg <= word;
            cnt   <= done ? '0 : cnt + 1'b1;
        end else if (expire) begin
            cnt   <= '0;
            shreg <= '0;
        end
    end

    // A completed word is dropped only when the held word is not being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
            overrun        <= 1'b0;
        end else begin
            overrun <= done && parallel_valid && !parallel_ready;
            if (done) begin
                if (!parallel_valid || parallel_ready) begin
                    parallel_data  <= word;
                    parallel_valid <= 1'b1;
                end
            end else if (parallel_valid && parallel_ready) begin
                parallel_valid <= 1'b0;
            end
        end
    end

endmodule
